// File: rtl/karatsuba_combine_seq.sv
// Sequential Karatsuba recombination: product = {z2,z0} + ((zm - z2 - z0) << 4) via one shared Kogge-Stone adder.
// Define KSC_OVF_CHECK_EN to add the sticky err output flagging inconsistent partial products.

module ksa16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);
   // Position 0 of the prefix tree carries cin as a generate term.
   logic [16:0] gl, pl, gn, pn;

   always_comb begin
      gl = {a & b, cin};
      pl = {a ^ b, 1'b0};
      gn = '0;
      pn = '0;
      for (int unsigned lvl = 0; lvl < 5; lvl++) begin
         gn = gl;
         pn = pl;
         for (int unsigned i = (1 << lvl); i < 17; i++) begin
            gn[i] = gl[i] | (pl[i] & gl[i - (1 << lvl)]);
            pn[i] = pl[i] & pl[i - (1 << lvl)];
         end
         gl = gn;
         pl = pn;
      end
      s    = (a ^ b) ^ gl[15:0];
      cout = gl[16];
   end
endmodule

module karatsuba_combine_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  z2,
   input  logic [7:0]  z0,
   input  logic [9:0]  zm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] product
`ifdef KSC_OVF_CHECK_EN
   ,
   output logic        err
`endif
);
   typedef enum logic [2:0] {IDLE, SUB2, SUB0, ADD, DONE} state_t;

   state_t      state;
   logic [15:0] z2_r, z0_r, zm_r, t;
   logic [15:0] add_a, add_b, add_s;
   logic        add_cin;
`ifdef KSC_OVF_CHECK_EN
   logic        add_cout;
`else
   logic        add_cout_unused;
`endif

   // Operand steering for the single shared adder; subtraction is A + ~B + 1.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state)
         SUB2: begin
            add_a   = zm_r;
            add_b   = ~z2_r;
            add_cin = 1'b1;
         end
         SUB0: begin
            add_a   = t;
            add_b   = ~z0_r;
            add_cin = 1'b1;
         end
         ADD: begin
            add_a = (z2_r << 8) | z0_r;
            add_b = t << 4;
         end
         default: ;
      endcase
   end

   ksa16 u_add (
      .a   (add_a),
      .b   (add_b),
      .cin (add_cin),
      .s   (add_s),
`ifdef KSC_OVF_CHECK_EN
      .cout(add_cout)
`else
      .cout(add_cout_unused)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         product   <= '0;
         z2_r      <= '0;
         z0_r      <= '0;
         zm_r      <= '0;
         t         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  z2_r     <= {8'h00, z2};
                  z0_r     <= {8'h00, z0};
                  zm_r     <= {6'h00, zm};
                  in_ready <= 1'b0;
                  state    <= SUB2;
               end
            end
            SUB2: begin
               t     <= add_s;
               state <= SUB0;
            end
            SUB0: begin
               t     <= add_s;
               state <= ADD;
            end
            ADD: begin
               product   <= add_s;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef KSC_OVF_CHECK_EN
   // Borrow out of either subtraction or carry out of the final add means the triple was inconsistent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if ((((state == SUB2) || (state == SUB0)) && !add_cout) ||
                   ((state == ADD) && add_cout)) begin
         err <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_karatsuba_combine_seq.sv
// Scoreboard bench for karatsuba_combine_seq: random and directed triples against an arithmetic reference.
// Checks err too when compiled with KSC_OVF_CHECK_EN.

module tb_karatsuba_combine_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  z2 = '0, z0 = '0;
   logic [9:0]  zm = '0;
   logic        in_ready, out_valid;
   logic [15:0] product;
`ifdef KSC_OVF_CHECK_EN
   logic        err;
`endif

   karatsuba_combine_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .z2       (z2),
      .z0       (z0),
      .zm       (zm),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .product  (product)
`ifdef KSC_OVF_CHECK_EN
      ,
      .err      (err)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] prod;
      logic        err;
      int unsigned issue;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   bit   hold_mode = 1'b0;
   bit   model_err = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic with explicit 16-bit wrap between steps.
   function automatic void ref_model(input logic [7:0] a2, input logic [7:0] a0, input logic [9:0] am,
                                     output logic [15:0] prod, output bit bad);
      longint t1, t2, sum;
      t1   = (longint'(am) - longint'(a2) + 65536) % 65536;
      t2   = (t1 - longint'(a0) + 65536) % 65536;
      sum  = longint'(a2) * 256 + longint'(a0) + (t2 * 16) % 65536;
      bad  = (am < a2) || (t1 < a0) || (sum > 65535);
      prod = 16'(sum % 65536);
   endfunction

   task automatic send(input logic [7:0] a2, input logic [7:0] a0, input logic [9:0] am,
                       input logic [15:0] prod);
      int unsigned w = 0;
      logic [15:0] dummy;
      bit          bad;
      exp_t        e;
      @(negedge clk);
      while (!in_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", in_ready, 1);
         return;
      end
      ref_model(a2, a0, am, dummy, bad);
      model_err = model_err | bad;
      e.prod  = prod;
      e.err   = model_err;
      e.issue = cyc;
      sb.push_back(e);
      in_valid = 1'b1;
      z2 = a2;
      z0 = a0;
      zm = am;
      @(negedge clk);
      in_valid = 1'b0;
      z2 = 8'($urandom);
      z0 = 8'($urandom);
      zm = 10'($urandom);
   endtask

   task automatic send_ab(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] a1, a0, b1, b0;
      a1 = a[7:4];
      a0 = a[3:0];
      b1 = b[7:4];
      b0 = b[3:0];
      send(8'(a1 * b1), 8'(a0 * b0), 10'((5'(a1) + 5'(a0)) * (5'(b1) + 5'(b0))), 16'(a * b));
   endtask

   task automatic send_raw(input logic [7:0] a2, input logic [7:0] a0, input logic [9:0] am);
      logic [15:0] p;
      bit          bad;
      ref_model(a2, a0, am, p, bad);
      send(a2, a0, am, p);
   endtask

   task automatic drain();
      int unsigned w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
   endtask

   task automatic wait_idle();
      int unsigned w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("idle_timeout", in_ready, 1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!hold_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compares on each new out_valid and checks the result is held while waiting.
   initial begin
      bit          prev = 1'b0;
      logic [15:0] held = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (out_valid && !prev) begin
            if (sb.size() == 0) begin
               check("unexpected_out_valid", out_valid, 0);
            end else begin
               e = sb.pop_front();
               held = e.prod;
               check("product", product, e.prod);
               check("latency", cyc - e.issue, 4);
`ifdef KSC_OVF_CHECK_EN
               check("err", err, e.err);
`endif
            end
         end else if (out_valid && prev) begin
            check("product_hold", product, held);
         end
         prev = out_valid;
      end
   end

   initial begin
      int unsigned w;
      logic [7:0] ca [6];
      ca[0] = 8'h00; ca[1] = 8'h01; ca[2] = 8'h0F;
      ca[3] = 8'h10; ca[4] = 8'h80; ca[5] = 8'hFF;

      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
`ifdef KSC_OVF_CHECK_EN
      check("rst_err", err, 0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;

      send(8'hE1, 8'hE1, 10'h384, 16'hFE01);
      send(8'h03, 8'h08, 10'h015, 16'h03A8);
      drain();

      // Consumer stall with stray in_valid pulses.
      wait_idle();
      hold_mode = 1'b1;
      out_ready = 1'b0;
      send(8'h03, 8'h08, 10'h015, 16'h03A8);
      w = 0;
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("hold_reach_done", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         z2 = 8'($urandom);
         z0 = 8'($urandom);
         zm = 10'($urandom);
         @(negedge clk);
         check("hold_product", product, 16'h03A8);
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      check("release_out_valid", out_valid, 0);
      out_ready = 1'b0;
      hold_mode = 1'b0;
      repeat (3) @(negedge clk);

      // Reset asserted while the triple sits in SUB0.
      send_ab(8'h9C, 8'h57);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_product", product, 0);
`ifdef KSC_OVF_CHECK_EN
      check("abort_err", err, 0);
`endif
      sb.delete();
      model_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("abort_no_valid", out_valid, 0);
      end
      send_ab(8'h9C, 8'h57);
      drain();

`ifdef KSC_OVF_CHECK_EN
      send_raw(8'h10, 8'h10, 10'h000);
      @(negedge clk);
      check("err_after_sub2", err, 1);
      drain();
      send_ab(8'h12, 8'h34);
      send_ab(8'h05, 8'h07);
      drain();
`endif

      foreach (ca[i]) foreach (ca[j]) send_ab(ca[i], ca[j]);
      repeat (400) send_ab(8'($urandom), 8'($urandom));
      repeat (60) send_raw(8'($urandom), 8'($urandom), 10'($urandom));
      drain();
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
